// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among N_REQ requesters.
// Grants are held for bursts of up to MAX_BURST beats; output is one registered stage tagged with the source id.
module stream_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       i_valid,
    output logic [N_REQ-1:0]       i_ready,
    input  logic [N_REQ*WIDTH-1:0] i_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [ID_W-1:0]        o_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  next_grant;
    logic [ID_W-1:0]  grant_inc;
    logic [ID_W-1:0]  rr_idx;
    logic [CNT_W-1:0] beat_cnt;
    logic             found;
    logic             load;
    logic             xfer;
    logic             last_beat;
    logic [WIDTH-1:0] sel_data;

    assign load      = !o_valid || o_ready;
    assign xfer      = |(i_valid & i_ready);
    assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign grant_inc = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);

    // Ready goes only to the granted requester, and only when the output register can take a beat.
    always_comb begin
        i_ready  = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant == ID_W'(k)) begin
                sel_data   = i_data[k*WIDTH +: WIDTH];
                i_ready[k] = (state == GRANT) && load;
            end
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        next_grant = rr_ptr;
        found      = 1'b0;
        rr_idx     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rr_idx = ID_W'((32'(rr_ptr) + i) % N_REQ);
            if (!found && i_valid[rr_idx]) begin
                found      = 1'b1;
                next_grant = rr_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            beat_cnt <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_id     <= '0;
        end else begin
            if (load) begin
                o_valid <= xfer;
                if (xfer) begin
                    o_data <= sel_data;
                    o_id   <= grant;
                end
            end

            case (state)
                IDLE: begin
                    if (|i_valid) begin
                        grant    <= next_grant;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // With load high, no transfer means the granted requester dropped valid.
                    if (load) begin
                        if (!xfer || last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= grant_inc;
                        end
                        if (xfer) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: cycle table for the fairness run, scoreboard for every output beat,
// and directed sequences for early release, stall, wrap and mid-burst reset.
module tb_stream_rr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk;
    logic           reset;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   i_ready;
    logic [N*W-1:0] i_data;
    logic           o_valid;
    logic           o_ready;
    logic [W-1:0]   o_data;
    logic [1:0]     o_id;

    stream_rr_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .MAX_BURST(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_data (i_data),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_id   (o_id)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic [3:0]  vld;
        logic        ordy;
        logic        ov;
        logic [1:0]  id;
        logic [15:0] data;
        logic [3:0]  rdy;
    } vec_t;

    beat_t       exp_q[$];
    beat_t       mb;
    vec_t        tbl[23];
    logic [15:0] cnt[N];
    logic        cnt_clr;
    int          checks = 0;
    int          errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Requester k sends k*256 + (number of beats it has had accepted).
    always_comb begin
        i_data = '0;
        for (int k = 0; k < N; k++) i_data[k*W +: W] = 16'(k * 256) + cnt[k];
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (cnt_clr) cnt[k] <= '0;
            else if (reset && i_valid[k] && i_ready[k]) cnt[k] <= cnt[k] + 16'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got id %0d data %0h expected no beat", o_id, o_data);
            end else begin
                mb = exp_q.pop_front();
                check("beat_id", 32'(o_id), 32'(mb.id));
                check("beat_data", 32'(o_data), 32'(mb.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input int id, input int first, input int n);
        for (int j = 0; j < n; j++) exp_q.push_back('{id: 2'(id), data: 16'(first + j)});
    endtask

    task automatic wait_cnt(input int r, input int n);
        int g = 0;
        while (cnt[r] != 16'(n) && g < 60) begin
            tick();
            g++;
        end
        check("wait_cnt", 32'(cnt[r]), 32'(n));
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 40) begin
            tick();
            g++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        cnt_clr = 1'b1;
        i_valid = '0;
        o_ready = 1'b1;
        repeat (2) tick();
        reset   = 1'b1;
        cnt_clr = 1'b0;
    endtask

    // Requester 2 alone sends two beats then drops; expects IDLE with rr_ptr=3, then a grant matching exp_rdy.
    task automatic early_release(input logic [3:0] next_mask, input logic [3:0] exp_rdy);
        i_valid = 4'b0100;
        wait_cnt(2, 2);
        i_valid = next_mask;
        tick();
        @(negedge clk);
        check("drop_state_idle", 32'(dut.state), 0);
        check("drop_rr_ptr", 32'(dut.rr_ptr), 3);
        check("drop_i_ready", 32'(i_ready), 0);
        tick();
        @(negedge clk);
        check("regrant_i_ready", 32'(i_ready), 32'(exp_rdy));
    endtask

    initial begin
        for (int c = 0; c < 23; c++)
            tbl[c] = '{vld: 4'hF, ordy: 1'b1, ov: 1'b0, id: 2'd0, data: 16'd0, rdy: 4'h0};
        for (int b = 0; b < 5; b++) begin
            tbl[1 + 5*b].rdy = 4'b0001 << (b % 4);
            for (int j = 0; j < 4; j++) begin
                if (2 + 5*b + j < 23) begin
                    tbl[2 + 5*b + j].ov   = 1'b1;
                    tbl[2 + 5*b + j].id   = 2'(b % 4);
                    tbl[2 + 5*b + j].data = 16'((b % 4) * 256 + (b / 4) * 4 + j);
                    tbl[2 + 5*b + j].rdy  = (j < 3) ? (4'b0001 << (b % 4)) : 4'b0000;
                end
            end
        end

        // Reset with every requester asserting valid.
        reset   = 1'b0;
        cnt_clr = 1'b1;
        i_valid = '1;
        o_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_ready", 32'(i_ready), 0);
        check("rst_o_valid", 32'(o_valid), 0);
        check("rst_o_data", 32'(o_data), 0);
        check("rst_o_id", 32'(o_id), 0);

        // Fairness: four full bursts in index order, one bubble each, then back to requester 0.
        for (int r = 0; r < 4; r++) push_burst(r, r * 256, 4);
        push_burst(0, 4, 1);
        tick();
        reset   = 1'b1;
        cnt_clr = 1'b0;
        for (int c = 0; c < 23; c++) begin
            if (c > 0) tick();
            i_valid = tbl[c].vld;
            o_ready = tbl[c].ordy;
            @(negedge clk);
            check("tbl_o_valid", 32'(o_valid), 32'(tbl[c].ov));
            check("tbl_i_ready", 32'(i_ready), 32'(tbl[c].rdy));
            if (tbl[c].ov) begin
                check("tbl_o_id", 32'(o_id), 32'(tbl[c].id));
                check("tbl_o_data", 32'(o_data), 32'(tbl[c].data));
            end
        end
        tick();
        check("fair_drain", 32'(exp_q.size()), 0);
        do_reset();

        // Early release, then requester 1 takes the next grant.
        push_burst(2, 512, 2);
        push_burst(1, 256, 4);
        early_release(4'b0010, 4'b0010);
        wait_cnt(1, 4);
        i_valid = '0;
        drain("early_drain");
        do_reset();

        // Output stall mid-burst from requester 3.
        push_burst(3, 768, 5);
        i_valid = 4'b1000;
        wait_cnt(3, 2);
        o_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_o_valid", 32'(o_valid), 1);
            check("stall_o_data", 32'(o_data), 32'h301);
            check("stall_o_id", 32'(o_id), 3);
            check("stall_i_ready", 32'(i_ready), 0);
            tick();
        end
        o_ready = 1'b1;
        wait_cnt(3, 4);
        @(negedge clk);
        check("burst_end_i_ready", 32'(i_ready), 0);
        check("burst_end_o_data", 32'(o_data), 32'h303);
        tick();
        @(negedge clk);
        check("single_regrant", 32'(i_ready), 32'h8);
        check("single_bubble", 32'(o_valid), 0);
        tick();
        i_valid = '0;
        drain("stall_drain");
        do_reset();

        // Wrap: rr_ptr=3 with requesters 0 and 1 valid grants 0 first, then 1.
        push_burst(2, 512, 2);
        push_burst(0, 0, 4);
        push_burst(1, 256, 4);
        early_release(4'b0011, 4'b0001);
        wait_cnt(0, 4);
        i_valid = 4'b0010;
        @(negedge clk);
        check("wrap_rr_ptr", 32'(dut.rr_ptr), 1);
        wait_cnt(1, 4);
        i_valid = '0;
        drain("wrap_drain");
        do_reset();

        // Reset mid-burst: the beat held in the output register is discarded.
        push_burst(0, 0, 4);
        push_burst(2, 513, 4);
        i_valid = 4'b0100;
        wait_cnt(2, 1);
        check("pre_rst_o_valid", 32'(o_valid), 1);
        check("pre_rst_grant", 32'(dut.grant), 2);
        reset   = 1'b0;
        i_valid = 4'b0101;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_o_valid", 32'(o_valid), 0);
        check("midrst_state", 32'(dut.state), 0);
        check("midrst_i_ready", 32'(i_ready), 0);
        tick();
        @(negedge clk);
        check("midrst_regrant", 32'(i_ready), 32'h1);
        wait_cnt(0, 4);
        i_valid = 4'b0100;
        wait_cnt(2, 5);
        i_valid = '0;
        drain("midrst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
